// File: rtl/gpr_write_scheduler.sv
// Write-port scheduler: arbitrates two writeback ports into an in-order queue
// that drains one write per cycle onto the register file's single write port.
module gpr_write_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aValid,
    input  logic [0:4]  aRw,
    input  logic [0:31] aBusW,
    output logic        aReady,
    input  logic        mValid,
    input  logic [0:4]  mRw,
    input  logic [0:31] mBusW,
    output logic        mReady,
    input  logic        wbHold,
    output logic        regWr,
    output logic [0:4]  Rw,
    output logic [0:31] busW,
    output logic [0:31] busy,
    output logic [0:3]  wrPending
);

    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [0:4]       q_rw   [DEPTH];
    logic [0:31]      q_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    tail_1;
    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             rr_ptr;

    logic        a_nz;
    logic        m_nz;
    logic        pop;
    logic        grant_a;
    logic        grant_m;
    logic        push0;
    logic        push1;
    logic [0:4]  push0_rw;
    logic [0:31] push0_data;
    logic [0:4]  push1_rw;
    logic [0:31] push1_data;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Arbitration: R0 requests never compete for slots.
    always_comb begin
        a_nz    = aValid & (aRw != '0);
        m_nz    = mValid & (mRw != '0);
        pop     = (count != '0) & ~wbHold;
        free    = DEPTH_W - count + CW'(pop);
        grant_a = 1'b0;
        grant_m = 1'b0;
        if (free >= CW'(2)) begin
            grant_a = a_nz;
            grant_m = m_nz;
        end else if (free == CW'(1)) begin
            if (!rr_ptr) begin
                grant_a = a_nz;
                grant_m = ~a_nz & m_nz;
            end else begin
                grant_m = m_nz;
                grant_a = ~m_nz & a_nz;
            end
        end
        aReady = grant_a | (aValid & (aRw == '0));
        mReady = grant_m | (mValid & (mRw == '0));
    end

    // Enqueue ordering: priority port first when both are granted.
    always_comb begin
        push0      = grant_a | grant_m;
        push1      = grant_a & grant_m;
        tail_1     = wrap_inc(tail);
        push0_rw   = aRw;
        push0_data = aBusW;
        push1_rw   = mRw;
        push1_data = mBusW;
        if ((push1 && rr_ptr) || (!push1 && grant_m)) begin
            push0_rw   = mRw;
            push0_data = mBusW;
            push1_rw   = aRw;
            push1_data = aBusW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_ptr <= 1'b0;
            vld    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                q_rw[k]   <= '0;
                q_data[k] <= '0;
            end
        end else begin
            // Pop clears before push sets, so a full-queue push into the head slot survives.
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= wrap_inc(head);
            end
            if (push0) begin
                q_rw[tail]   <= push0_rw;
                q_data[tail] <= push0_data;
                vld[tail]    <= 1'b1;
            end
            if (push1) begin
                q_rw[tail_1]   <= push1_rw;
                q_data[tail_1] <= push1_data;
                vld[tail_1]    <= 1'b1;
            end
            if (push1)
                tail <= wrap_inc(tail_1);
            else if (push0)
                tail <= tail_1;
            count <= count + CW'(grant_a) + CW'(grant_m) - CW'(pop);
            if (a_nz && m_nz && (grant_a || grant_m))
                rr_ptr <= ~rr_ptr;
        end
    end

    // Register-file drive and scoreboard view of in-flight writes.
    always_comb begin
        regWr     = pop;
        Rw        = pop ? q_rw[head]   : '0;
        busW      = pop ? q_data[head] : '0;
        wrPending = count;
        busy      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[k]) busy[q_rw[k]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Bench for gpr_write_scheduler: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_gpr_write_scheduler;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        src;
        logic [4:0]  rw;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, m_valid, wb_hold;
    logic [0:4]  a_rw, m_rw;
    logic [0:31] a_bus, m_bus;
    logic        a_ready, m_ready, reg_wr;
    logic [0:4]  rw_out;
    logic [0:31] bus_out;
    logic [0:31] busy;
    logic [0:3]  pending;

    int n_vec = 0;
    int n_err = 0;

    ent_t mq[$];
    bit   rr = 1'b0;
    bit   a_acc = 1'b0;
    bit   m_acc = 1'b0;

    gpr_write_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .aValid(a_valid), .aRw(a_rw), .aBusW(a_bus), .aReady(a_ready),
        .mValid(m_valid), .mRw(m_rw), .mBusW(m_bus), .mReady(m_ready),
        .wbHold(wb_hold), .regWr(reg_wr), .Rw(rw_out), .busW(bus_out),
        .busy(busy), .wrPending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: grants fill free slots in priority order, queue drains FIFO.
    always @(negedge clk or posedge reset) begin : model
        int          cnt;
        int          free;
        bit          pop, a_nz, m_nz, ga, gm;
        ent_t        cand[$];
        logic [0:31] e_busy;
        logic [4:0]  e_rw;
        logic [31:0] e_d;
        if (reset) begin
            mq.delete();
            rr    = 1'b0;
            a_acc = 1'b0;
            m_acc = 1'b0;
        end else begin
            cnt  = mq.size();
            pop  = (cnt != 0) && !wb_hold;
            free = DEPTH - cnt + (pop ? 1 : 0);
            a_nz = a_valid && (a_rw != 0);
            m_nz = m_valid && (m_rw != 0);
            cand.delete();
            if (rr) begin
                if (m_nz) cand.push_back({1'b1, 5'(m_rw), 32'(m_bus)});
                if (a_nz) cand.push_back({1'b0, 5'(a_rw), 32'(a_bus)});
            end else begin
                if (a_nz) cand.push_back({1'b0, 5'(a_rw), 32'(a_bus)});
                if (m_nz) cand.push_back({1'b1, 5'(m_rw), 32'(m_bus)});
            end
            while (cand.size() > free) void'(cand.pop_back());
            ga = 1'b0;
            gm = 1'b0;
            foreach (cand[k]) begin
                if (cand[k].src) gm = 1'b1;
                else             ga = 1'b1;
            end
            e_rw = '0;
            e_d  = '0;
            if (pop) begin
                e_rw = mq[0].rw;
                e_d  = mq[0].d;
            end
            e_busy = '0;
            foreach (mq[k]) e_busy[mq[k].rw] = 1'b1;
            a_acc = ga || (a_valid && a_rw == 0);
            m_acc = gm || (m_valid && m_rw == 0);
            chk("aReady", 32'(a_ready), 32'(a_acc));
            chk("mReady", 32'(m_ready), 32'(m_acc));
            chk("regWr", 32'(reg_wr), 32'(pop));
            chk("Rw", 32'(rw_out), 32'(e_rw));
            chk("busW", 32'(bus_out), e_d);
            chk("busy", 32'(busy), 32'(e_busy));
            chk("wrPending", 32'(pending), 32'(cnt));
            if (pop) void'(mq.pop_front());
            foreach (cand[k]) mq.push_back(cand[k]);
            if (a_nz && m_nz && (ga || gm)) rr = ~rr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_rw = '0; a_bus = '0;
        m_valid = 1'b0; m_rw = '0; m_bus = '0;
    endtask

    task automatic drv_a(input logic [4:0] r, input logic [31:0] d);
        a_valid = 1'b1; a_rw = r; a_bus = d;
    endtask

    task automatic drv_m(input logic [4:0] r, input logic [31:0] d);
        m_valid = 1'b1; m_rw = r; m_bus = d;
    endtask

    initial begin : stim
        logic [0:31] b;
        logic [4:0]  exp_rw [4];
        logic [31:0] exp_d  [4];
        exp_rw = '{5'd3, 5'd3, 5'd4, 5'd4};
        exp_d  = '{32'h1, 32'h2, 32'h4, 32'h3};

        reset = 1'b1; wb_hold = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_regWr", 32'(reg_wr), 32'd0);
        chk("rst_Rw", 32'(rw_out), 32'd0);
        chk("rst_busW", 32'(bus_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);

        // Single write latency
        step(); drv_a(5'd5, 32'hDEADBEEF);
        #1 chk("single_aReady", 32'(a_ready), 32'd1);
        step(); idle();
        #1;
        b = '0; b[5] = 1'b1;
        chk("single_regWr", 32'(reg_wr), 32'd1);
        chk("single_Rw", 32'(rw_out), 32'd5);
        chk("single_busW", 32'(bus_out), 32'hDEADBEEF);
        chk("single_busy", 32'(busy), 32'(b));
        step();
        #1;
        chk("single_done_regWr", 32'(reg_wr), 32'd0);
        chk("single_done_busy", 32'(busy), 32'd0);

        // Same-cycle contention ordering under hold
        step(); wb_hold = 1'b1; drv_a(5'd3, 32'h1); drv_m(5'd3, 32'h2);
        #1 chk("cont1_ready", 32'({a_ready, m_ready}), 32'd3);
        step(); drv_a(5'd4, 32'h3); drv_m(5'd4, 32'h4);
        #1 chk("cont2_ready", 32'({a_ready, m_ready}), 32'd3);
        step(); idle(); wb_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_regWr", 32'(reg_wr), 32'd1);
            chk("drain_Rw", 32'(rw_out), 32'(exp_rw[k]));
            chk("drain_busW", 32'(bus_out), exp_d[k]);
            step();
        end
        #1 chk("drain_empty", 32'(pending), 32'd0);

        // Full queue backpressure and R0 discard
        step(); wb_hold = 1'b1; drv_a(5'd1, 32'h11); drv_m(5'd2, 32'h22);
        step(); drv_a(5'd6, 32'h66); drv_m(5'd7, 32'h77);
        step(); drv_a(5'd8, 32'h88); drv_m(5'd9, 32'h99);
        #1;
        chk("full_pending", 32'(pending), 32'd4);
        chk("full_aReady", 32'(a_ready), 32'd0);
        chk("full_mReady", 32'(m_ready), 32'd0);
        step(); idle(); drv_m(5'd0, 32'h5);
        #1 chk("r0_mReady", 32'(m_ready), 32'd1);
        step(); idle();
        #1;
        b = busy;
        chk("r0_pending", 32'(pending), 32'd4);
        chk("r0_busy0", 32'(b[0]), 32'd0);
        drv_a(5'd8, 32'h88); drv_m(5'd9, 32'h99); wb_hold = 1'b0;
        #1 chk("release_ready", 32'({a_ready, m_ready}), 32'd2);
        step(); a_valid = 1'b0;
        #1 chk("release_next_mReady", 32'(m_ready), 32'd1);
        step(); idle();
        repeat (6) step();

        // Reset mid-operation
        wb_hold = 1'b1; drv_a(5'd10, 32'hA0); drv_m(5'd11, 32'hB0);
        step(); m_valid = 1'b0; drv_a(5'd12, 32'hC0);
        step(); idle(); wb_hold = 1'b0;
        #1;
        chk("prerst_regWr", 32'(reg_wr), 32'd1);
        chk("prerst_pending", 32'(pending), 32'd3);
        reset = 1'b1;
        #1;
        chk("midrst_regWr", 32'(reg_wr), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postrst_regWr", 32'(reg_wr), 32'd0);
        end

        // Randomized traffic; a request is held until the model says it was taken
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(a_valid && !a_acc)) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rw    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
                a_bus   = $urandom;
            end
            if (!(m_valid && !m_acc)) begin
                m_valid = ($urandom_range(0, 99) < 60);
                m_rw    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                m_bus   = $urandom;
            end
            wb_hold = ($urandom_range(0, 99) < 35);
        end
        step(); idle(); wb_hold = 1'b0;
        repeat (8) step();
        chk("final_pending", 32'(pending), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
